// File: rtl/dec_2_pkg.sv
// dec_2_pkg: shared definitions for the dec_2 decoder dense layer.
//   BITSIZE_DEFAULT : default width of one signed Q8.8 fixed-point element
//   FRAC_BITS       : number of fractional bits in the fixed-point format
//   state_t         : controller state encoding (IDLE, RUN, DRAIN)
package dec_2_pkg;

  localparam int BITSIZE_DEFAULT = 16;
  localparam int FRAC_BITS       = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage : dec_2_pkg

// File: rtl/fixed_point_add.sv
// fixed_point_add: two's-complement fixed-point sum, combinational.
//   a, b : operands, BITSIZE wide (same Q format)
//   s    : a + b, wrapping on overflow
module fixed_point_add #(
  parameter int BITSIZE = 16
) (
  input  logic [BITSIZE-1:0] a,
  input  logic [BITSIZE-1:0] b,
  output logic [BITSIZE-1:0] s
);

  assign s = a + b;

endmodule : fixed_point_add

// File: rtl/fixed_point_multiply.sv
// fixed_point_multiply: signed fixed-point product, combinational.
//   a, b : signed operands, BITSIZE wide, FRAC_BITS fractional bits
//   p    : product realigned to the operand format and truncated to BITSIZE
//          (low fractional bits dropped, high integer bits wrap)
module fixed_point_multiply #(
  parameter int BITSIZE   = 16,
  parameter int FRAC_BITS = 8
) (
  input  logic [BITSIZE-1:0] a,
  input  logic [BITSIZE-1:0] b,
  output logic [BITSIZE-1:0] p
);

  logic signed [2*BITSIZE-1:0] full;
  logic signed [2*BITSIZE-1:0] aligned;

  assign full    = (2*BITSIZE)'(signed'(a)) * (2*BITSIZE)'(signed'(b));
  assign aligned = full >>> FRAC_BITS;
  assign p       = BITSIZE'(aligned);

endmodule : fixed_point_multiply

// File: rtl/fixed_point_relu.sv
// fixed_point_relu: rectifier on a signed fixed-point value, combinational.
//   a : signed input, BITSIZE wide
//   y : a when a >= 0, zero when a is negative (MSB set)
module fixed_point_relu #(
  parameter int BITSIZE = 16
) (
  input  logic [BITSIZE-1:0] a,
  output logic [BITSIZE-1:0] y
);

  assign y = a[BITSIZE-1] ? '0 : a;

endmodule : fixed_point_relu

// File: rtl/dec_2.sv
// dec_2: decoder-side dense layer, expands one latent element x into N_OUT
// outputs y[i] = x*w[i] + b[i] using one shared multiplier and one shared
// adder in a two-stage pipeline.
//
// Ports:
//   clk       : rising-edge clock
//   reset     : asynchronous, active-low reset
//   start     : request a computation (only looked at in IDLE)
//   x         : latent input element, BITSIZE wide
//   w, b      : weight column / bias vector, element i at [BITSIZE*i +: BITSIZE]
//   busy      : high while a computation is in flight
//   done      : one-cycle pulse when the last output has been written
//   valid     : high while y holds a complete, current result
//   y         : output vector, same packing as w
//   dbg_state : current controller state
//
// Build option: define DEC_2_RELU_EN to pass every result through a ReLU
// before it is written; timing is the same either way.
//
// Handshake: start is a request sampled only while the controller is IDLE
// (starts seen while busy are dropped, there is no ready/ack back). The
// operands are captured on the accepting edge, so x/w/b may change after it.
// Completion is signalled by a single-cycle done pulse, together with busy
// falling and valid rising; valid then stays high until the next accepted
// start or a reset.
module dec_2
  import dec_2_pkg::*;
#(
  parameter int BITSIZE = BITSIZE_DEFAULT,
  parameter int N_OUT   = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [BITSIZE-1:0]       x,
  input  logic [BITSIZE*N_OUT-1:0] w,
  input  logic [BITSIZE*N_OUT-1:0] b,
  output logic                     busy,
  output logic                     done,
  output logic                     valid,
  output logic [BITSIZE*N_OUT-1:0] y,
  output state_t                   dbg_state
);

  localparam int            IW     = $clog2(N_OUT);
  localparam int            KW     = IW + 1;
  localparam logic [KW-1:0] K_LAST = KW'(N_OUT - 1);

  state_t             state;
  logic [KW-1:0]      k;
  logic [BITSIZE-1:0] x_cap;
  logic [BITSIZE-1:0] w_cap [N_OUT];
  logic [BITSIZE-1:0] b_cap [N_OUT];
  logic [BITSIZE-1:0] y_arr [N_OUT];

  // Stage-2 pipeline registers: product, its element index and a flag.
  logic [BITSIZE-1:0] prod_reg;
  logic [IW-1:0]      idx_reg;
  logic               s2_valid;

  logic [BITSIZE-1:0] mul_p;
  logic [BITSIZE-1:0] add_s;
  logic [BITSIZE-1:0] stage2_res;

  fixed_point_multiply #(
    .BITSIZE  (BITSIZE),
    .FRAC_BITS(FRAC_BITS)
  ) u_mul (
    .a(x_cap),
    .b(w_cap[IW'(k)]),
    .p(mul_p)
  );

  fixed_point_add #(
    .BITSIZE(BITSIZE)
  ) u_add (
    .a(prod_reg),
    .b(b_cap[idx_reg]),
    .s(add_s)
  );

`ifdef DEC_2_RELU_EN
  fixed_point_relu #(
    .BITSIZE(BITSIZE)
  ) u_relu (
    .a(add_s),
    .y(stage2_res)
  );
`else
  assign stage2_res = add_s;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      k        <= '0;
      x_cap    <= '0;
      prod_reg <= '0;
      idx_reg  <= '0;
      s2_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      valid    <= 1'b0;
      for (int i = 0; i < N_OUT; i++) begin
        w_cap[i] <= '0;
        b_cap[i] <= '0;
        y_arr[i] <= '0;
      end
    end else begin
      done     <= 1'b0;
      s2_valid <= 1'b0;

      // Stage 2 retires independently of the controller state.
      if (s2_valid) begin
        y_arr[idx_reg] <= stage2_res;
      end

      case (state)
        IDLE: begin
          if (start) begin
            x_cap <= x;
            for (int i = 0; i < N_OUT; i++) begin
              w_cap[i] <= w[BITSIZE*i +: BITSIZE];
              b_cap[i] <= b[BITSIZE*i +: BITSIZE];
            end
            k     <= '0;
            valid <= 1'b0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end

        RUN: begin
          prod_reg <= mul_p;
          idx_reg  <= IW'(k);
          s2_valid <= 1'b1;
          // k parks on the last index so it never leaves the array range.
          if (k == K_LAST) begin
            state <= DRAIN;
          end else begin
            k <= k + 1'b1;
          end
        end

        DRAIN: begin
          // The last product retires on this edge through the stage-2 write.
          busy  <= 1'b0;
          done  <= 1'b1;
          valid <= 1'b1;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_y
    assign y[BITSIZE*gi +: BITSIZE] = y_arr[gi];
  end

  assign dbg_state = state;

endmodule : dec_2

// File: tb/tb_dec_2.sv
// tb_dec_2: directed self-checking bench for dec_2 (default parameters).
module tb_dec_2;
  import dec_2_pkg::*;

  localparam int W = 16;
  localparam int N = 6;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [W-1:0]   x;
  logic [W*N-1:0] w;
  logic [W*N-1:0] b;
  logic           busy;
  logic           done;
  logic           valid;
  logic [W*N-1:0] y;
  state_t         dbg_state;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] exp_y [N];

  dec_2 #(.BITSIZE(W), .N_OUT(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .x        (x),
    .w        (w),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .valid    (valid),
    .y        (y),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic load_uniform(input logic [W-1:0] xv, input logic [W-1:0] wv,
                              input logic [W-1:0] bv);
    x = xv;
    for (int i = 0; i < N; i++) begin
      w[W*i +: W] = wv;
      b[W*i +: W] = bv;
    end
  endtask

  // One-cycle start pulse, then watch `window` cycles. Cycle c is the
  // falling edge after the c-th rising edge following the start edge E0.
  task automatic run_and_watch(input int window, output int first_done,
                               output int done_cnt, output int busy_cnt);
    first_done = -1;
    done_cnt   = 0;
    busy_cnt   = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (busy) busy_cnt++;
    for (int c = 1; c <= window; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (first_done < 0) first_done = c;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b0;
    start = 1'b0;
    load_uniform(16'h0000, 16'h0000, 16'h0000);
    repeat (3) @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags: busy=%b done=%b valid=%b, required 0 0 0", busy, done, valid);
    end
    n_vec++;
    if (y !== '0) begin
      n_err++;
      $display("FAIL reset_y: got %h, required 0", y);
    end
    n_vec++;
    if (dbg_state !== IDLE) begin
      n_err++;
      $display("FAIL reset_state: got %0d, required %0d", dbg_state, IDLE);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int done_at = -1;
    int busy_cnt = 0;
    int done_cnt = 0;
    load_uniform(16'h0100, 16'h0200, 16'h0080);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (busy) busy_cnt++;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      if (c < 7) begin
        n_vec++;
        if (valid !== 1'b0) begin
          n_err++;
          $display("FAIL basic_valid_low c=%0d: got %b, required 0", c, valid);
        end
      end
    end
    n_vec++;
    if (done_at != 7) begin
      n_err++;
      $display("FAIL basic_done_cycle: got %0d, required 7", done_at);
    end
    n_vec++;
    if (done_cnt != 1) begin
      n_err++;
      $display("FAIL basic_done_count: got %0d, required 1", done_cnt);
    end
    n_vec++;
    if (busy_cnt != 7) begin
      n_err++;
      $display("FAIL basic_busy_cycles: got %0d, required 7", busy_cnt);
    end
    n_vec++;
    if (valid !== 1'b1) begin
      n_err++;
      $display("FAIL basic_valid_high: got %b, required 1", valid);
    end
    for (int i = 0; i < N; i++) begin
      n_vec++;
      if (y[W*i +: W] !== 16'h0280) begin
        n_err++;
        $display("FAIL basic_y%0d: got %h, required 0280", i, y[W*i +: W]);
      end
    end
  endtask

  // Previous outputs are all 0x0280; watch each element switch on its edge.
  task automatic test_distinct;
    logic [W-1:0] nv [N];
    logic [W-1:0] e;
    x = 16'h0200;
    for (int i = 0; i < N; i++) begin
      w[W*i +: W] = W'(16'h0100 * (i + 1));
      b[W*i +: W] = 16'h0000;
      nv[i]       = W'(16'h0200 * (i + 1));
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        e = (i <= c - 2) ? nv[i] : 16'h0280;
        n_vec++;
        if (y[W*i +: W] !== e) begin
          n_err++;
          $display("FAIL distinct_y%0d c=%0d: got %h, required %h", i, c, y[W*i +: W], e);
        end
      end
      n_vec++;
      if (done !== (c == 7)) begin
        n_err++;
        $display("FAIL distinct_done c=%0d: got %b, required %b", c, done, (c == 7));
      end
    end
  endtask

  task automatic test_negative;
    int fd, dc, bc;
    load_uniform(16'h0100, 16'h0100, 16'h0000);
    w[W*3 +: W] = 16'hFE00;
    for (int i = 0; i < N; i++) exp_y[i] = 16'h0100;
`ifdef DEC_2_RELU_EN
    exp_y[3] = 16'h0000;
`else
    exp_y[3] = 16'hFE00;
`endif
    run_and_watch(8, fd, dc, bc);
    n_vec++;
    if (fd != 7 || dc != 1) begin
      n_err++;
      $display("FAIL negative_done: first=%0d count=%0d, required 7 1", fd, dc);
    end
    for (int i = 0; i < N; i++) begin
      n_vec++;
      if (y[W*i +: W] !== exp_y[i]) begin
        n_err++;
        $display("FAIL negative_y%0d: got %h, required %h", i, y[W*i +: W], exp_y[i]);
      end
    end
  endtask

  // Fractional products and bias carries in Q8.8.
  task automatic test_arith;
    int fd, dc, bc;
    x = 16'h0180;                                          // 1.5
    w[W*0 +: W] = 16'h0180; b[W*0 +: W] = 16'h0000;        // 2.25        -> 0240
    w[W*1 +: W] = 16'h0100; b[W*1 +: W] = 16'h0001;        // 1.5 + lsb   -> 0181
    w[W*2 +: W] = 16'hFF00; b[W*2 +: W] = 16'h0000;        // -1.5        -> FE80
    w[W*3 +: W] = 16'h0000; b[W*3 +: W] = 16'h1234;        // bias only   -> 1234
    w[W*4 +: W] = 16'h0040; b[W*4 +: W] = 16'hFFFF;        // 0.375 - lsb -> 005F
    w[W*5 +: W] = 16'h0001; b[W*5 +: W] = 16'h0000;        // 1.5/256 truncated -> 0001
    exp_y[0] = 16'h0240;
    exp_y[1] = 16'h0181;
`ifdef DEC_2_RELU_EN
    exp_y[2] = 16'h0000;
`else
    exp_y[2] = 16'hFE80;
`endif
    exp_y[3] = 16'h1234;
    exp_y[4] = 16'h005F;
    exp_y[5] = 16'h0001;
    run_and_watch(8, fd, dc, bc);
    n_vec++;
    if (fd != 7) begin
      n_err++;
      $display("FAIL arith_done: got %0d, required 7", fd);
    end
    for (int i = 0; i < N; i++) begin
      n_vec++;
      if (y[W*i +: W] !== exp_y[i]) begin
        n_err++;
        $display("FAIL arith_y%0d: got %h, required %h", i, y[W*i +: W], exp_y[i]);
      end
    end
  endtask

  task automatic test_start_while_busy;
    int done_at = -1;
    int done_cnt = 0;
    load_uniform(16'h0100, 16'h0500, 16'h0010);          // 5.0 + 0x10 -> 0510
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      start = (c == 1 || c == 3);                          // sampled at E2 and E4
      if (c == 1) x = 16'h0300;
    end
    start = 1'b0;
    n_vec++;
    if (done_cnt != 1 || done_at != 7) begin
      n_err++;
      $display("FAIL busy_start_done: first=%0d count=%0d, required 7 1", done_at, done_cnt);
    end
    for (int i = 0; i < N; i++) begin
      n_vec++;
      if (y[W*i +: W] !== 16'h0510) begin
        n_err++;
        $display("FAIL busy_start_y%0d: got %h, required 0510", i, y[W*i +: W]);
      end
    end
  endtask

  task automatic test_reset_mid_run;
    int fd, dc, bc;
    int stray = 0;
    load_uniform(16'h0100, 16'h0100, 16'h0000);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || valid !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_flags: busy=%b done=%b valid=%b, required 0 0 0", busy, done, valid);
    end
    n_vec++;
    if (y !== '0) begin
      n_err++;
      $display("FAIL midreset_y: got %h, required 0", y);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done || busy) stray++;
    end
    n_vec++;
    if (stray != 0) begin
      n_err++;
      $display("FAIL midreset_no_done: got %0d active cycles, required 0", stray);
    end
    load_uniform(16'h0080, 16'h0600, 16'h0100);          // 3.0 + 1.0 -> 0400
    run_and_watch(8, fd, dc, bc);
    n_vec++;
    if (fd != 7 || bc != 7) begin
      n_err++;
      $display("FAIL midreset_rerun_timing: done=%0d busy=%0d, required 7 7", fd, bc);
    end
    for (int i = 0; i < N; i++) begin
      n_vec++;
      if (y[W*i +: W] !== 16'h0400) begin
        n_err++;
        $display("FAIL midreset_rerun_y%0d: got %h, required 0400", i, y[W*i +: W]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int dones = 0;
    logic saw7 = 1'b0;
    logic saw15 = 1'b0;
    load_uniform(16'h0100, 16'h0300, 16'h0000);          // first run  -> 0300
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);                                      // c = 0, start still high
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      if (done) dones++;
      if (c == 1) load_uniform(16'h0080, 16'h0400, 16'h0001);  // second run -> 0201
      if (c == 7) begin
        saw7 = done;
        for (int i = 0; i < N; i++) begin
          n_vec++;
          if (y[W*i +: W] !== 16'h0300) begin
            n_err++;
            $display("FAIL b2b_first_y%0d: got %h, required 0300", i, y[W*i +: W]);
          end
        end
      end
      if (c == 8) begin
        n_vec++;
        if (valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
          n_err++;
          $display("FAIL b2b_restart: valid=%b busy=%b done=%b, required 0 1 0", valid, busy, done);
        end
        start = 1'b0;
      end
      if (c == 15) begin
        saw15 = done;
        n_vec++;
        if (valid !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_second_valid: got %b, required 1", valid);
        end
        for (int i = 0; i < N; i++) begin
          n_vec++;
          if (y[W*i +: W] !== 16'h0201) begin
            n_err++;
            $display("FAIL b2b_second_y%0d: got %h, required 0201", i, y[W*i +: W]);
          end
        end
      end
    end
    n_vec++;
    if (!saw7 || !saw15 || dones != 2) begin
      n_err++;
      $display("FAIL b2b_done_pulses: at7=%b at15=%b count=%0d, required 1 1 2", saw7, saw15, dones);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset;
    test_basic;
    test_distinct;
    test_negative;
    test_arith;
    test_start_while_busy;
    test_reset_mid_run;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard stop so the run can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule : tb_dec_2
